// File: rtl/load_store_unit.sv
// Load/store sequencer between the execute stage and a single-port, byte-addressable
// data memory: checks, issues one access, extends read data, holds the result until taken.
module load_store_unit #(
   parameter int unsigned MEM_BYTES   = 1024,
   parameter bit          CHECK_ALIGN = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WE,
   input  logic [2:0]  REQ_FUNCT3,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   output logic        RSP_VALID,
   input  logic        RSP_READY,
   output logic [31:0] RSP_RDATA,
   output logic        RSP_ERR,
   output logic [31:0] MEM_ADDR,
   output logic        MEM_CS,
   output logic        MEM_R_W,
   output logic [1:0]  MEM_BSEL,
   output logic [31:0] MEM_WDATA,
   input  logic [31:0] MEM_RDATA
);

   typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, DONE} state_t;

   state_t      state, state_nxt;
   logic        accept;
   logic        we_q;
   logic [2:0]  f3_q;
   logic [1:0]  size_m1;
   logic [1:0]  bsel_d;
   logic [31:0] wdata_d;
   logic        f3_ok, misalign, out_of_range, req_err;
   logic [32:0] last_byte;
   logic [31:0] load_ext;

   assign REQ_READY = (state == IDLE) && !RST;
   assign accept    = REQ_VALID && REQ_READY;
   assign MEM_CS    = (state == ACCESS);
   assign RSP_VALID = (state == DONE);

   always_comb begin
      size_m1  = 2'd0;
      bsel_d   = 2'b00;
      wdata_d  = '0;
      misalign = 1'b0;
      f3_ok    = 1'b0;
      case (REQ_FUNCT3[1:0])
         2'b00: begin
            size_m1 = 2'd0;
            bsel_d  = 2'b00;
            wdata_d = {24'h0, REQ_WDATA[7:0]};
         end
         2'b01: begin
            size_m1  = 2'd1;
            bsel_d   = 2'b01;
            wdata_d  = {16'h0, REQ_WDATA[15:0]};
            misalign = CHECK_ALIGN && REQ_ADDR[0];
         end
         default: begin
            size_m1  = 2'd3;
            bsel_d   = 2'b11;
            wdata_d  = REQ_WDATA;
            misalign = CHECK_ALIGN && (REQ_ADDR[1:0] != 2'b00);
         end
      endcase
      case (REQ_FUNCT3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = !REQ_WE;
         default:                f3_ok = 1'b0;
      endcase
      // 33-bit sum so an access near 0xFFFFFFFF cannot wrap back into range
      last_byte    = {1'b0, REQ_ADDR} + {31'h0, size_m1};
      out_of_range = (last_byte >= 33'(MEM_BYTES));
      req_err      = !f3_ok || misalign || out_of_range;
   end

   always_comb begin
      case (f3_q)
         3'b000:  load_ext = {{24{MEM_RDATA[7]}}, MEM_RDATA[7:0]};
         3'b001:  load_ext = {{16{MEM_RDATA[15]}}, MEM_RDATA[15:0]};
         3'b100:  load_ext = {24'h0, MEM_RDATA[7:0]};
         3'b101:  load_ext = {16'h0, MEM_RDATA[15:0]};
         default: load_ext = MEM_RDATA;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = req_err ? DONE : ACCESS;
         ACCESS:  state_nxt = we_q ? DONE : RDWAIT;
         RDWAIT:  state_nxt = DONE;
         DONE:    if (RSP_READY) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Memory-side outputs only change when a valid access is launched, so they hold otherwise
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         we_q      <= 1'b0;
         f3_q      <= 3'b000;
         RSP_RDATA <= '0;
         RSP_ERR   <= 1'b0;
         MEM_ADDR  <= '0;
         MEM_R_W   <= 1'b1;
         MEM_BSEL  <= 2'b00;
         MEM_WDATA <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  we_q <= REQ_WE;
                  f3_q <= REQ_FUNCT3;
                  if (req_err) begin
                     RSP_ERR   <= 1'b1;
                     RSP_RDATA <= '0;
                  end else begin
                     RSP_ERR  <= 1'b0;
                     MEM_ADDR <= REQ_ADDR;
                     MEM_R_W  <= !REQ_WE;
                     MEM_BSEL <= bsel_d;
                     if (REQ_WE) MEM_WDATA <= wdata_d;
                  end
               end
            end
            ACCESS: begin
               if (we_q) begin
                  RSP_RDATA <= '0;
                  RSP_ERR   <= 1'b0;
               end
            end
            RDWAIT: begin
               RSP_RDATA <= load_ext;
               RSP_ERR   <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table against a byte-array memory model,
// plus hand-written response-stall and mid-access reset sequences.
module tb_load_store_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REQ_VALID, REQ_READY, REQ_WE;
   logic [2:0]  REQ_FUNCT3;
   logic [31:0] REQ_ADDR, REQ_WDATA;
   logic        RSP_VALID, RSP_READY, RSP_ERR;
   logic [31:0] RSP_RDATA;
   logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
   logic        MEM_CS, MEM_R_W;
   logic [1:0]  MEM_BSEL;

   int n_tests = 0;
   int n_fail  = 0;

   load_store_unit #(.MEM_BYTES(1024), .CHECK_ALIGN(1'b1)) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WE(REQ_WE),
      .REQ_FUNCT3(REQ_FUNCT3), .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .MEM_ADDR(MEM_ADDR), .MEM_CS(MEM_CS), .MEM_R_W(MEM_R_W), .MEM_BSEL(MEM_BSEL),
      .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
   );

   always #5 CLK = ~CLK;

   // Memory model: registered read, low-aligned data, 0xA5 filler in unused upper bytes
   logic [7:0] mem [0:1023];
   logic [9:0] ma;
   assign ma = MEM_ADDR[9:0];
   always @(posedge CLK) begin
      if (MEM_CS) begin
         if (!MEM_R_W) begin
            mem[ma] <= MEM_WDATA[7:0];
            if (MEM_BSEL != 2'b00) mem[ma + 10'd1] <= MEM_WDATA[15:8];
            if (MEM_BSEL == 2'b11) begin
               mem[ma + 10'd2] <= MEM_WDATA[23:16];
               mem[ma + 10'd3] <= MEM_WDATA[31:24];
            end
         end else begin
            case (MEM_BSEL)
               2'b00:   MEM_RDATA <= {24'hA5A5A5, mem[ma]};
               2'b01:   MEM_RDATA <= {16'hA5A5, mem[ma + 10'd1], mem[ma]};
               default: MEM_RDATA <= {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
            endcase
         end
      end
   end

   // Access monitor: one sample per cycle, mid-cycle
   int          cs_total = 0;
   logic [31:0] cs_addr, cs_wdata;
   logic [1:0]  cs_bsel;
   logic        cs_rw;
   always @(negedge CLK) begin
      if (MEM_CS) begin
         cs_total = cs_total + 1;
         cs_addr  = MEM_ADDR;
         cs_wdata = MEM_WDATA;
         cs_bsel  = MEM_BSEL;
         cs_rw    = MEM_R_W;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      logic [1:0]  exp_bsel;
      logic [31:0] exp_wd;
   } vec_t;

   vec_t vecs[$];

   task automatic run_vec(input vec_t v, input string nm);
      int lat;
      int base;
      @(negedge CLK);
      REQ_WE = v.we; REQ_FUNCT3 = v.f3; REQ_ADDR = v.addr; REQ_WDATA = v.wdata;
      REQ_VALID = 1'b1;
      lat = 0;
      while (!REQ_READY && lat < 20) begin
         @(negedge CLK);
         lat++;
      end
      chk({nm, "_ready_wait"}, 32'(lat < 20), 32'd1);
      base = cs_total;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      lat = 1;
      while (!RSP_VALID && lat < 20) begin
         @(posedge CLK); #1;
         lat++;
      end
      chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
      chk({nm, "_err"}, 32'(RSP_ERR), 32'(v.exp_err));
      chk({nm, "_rdata"}, RSP_RDATA, v.exp_rdata);
      chk({nm, "_req_ready_done"}, 32'(REQ_READY), 32'd0);
      chk({nm, "_cs_cycles"}, 32'(cs_total - base), v.exp_err ? 32'd0 : 32'd1);
      if (!v.exp_err && (cs_total - base) == 1) begin
         chk({nm, "_mem_addr"}, cs_addr, v.addr);
         chk({nm, "_mem_bsel"}, 32'(cs_bsel), 32'(v.exp_bsel));
         chk({nm, "_mem_r_w"}, 32'(cs_rw), 32'(!v.we));
         if (v.we) chk({nm, "_mem_wdata"}, cs_wdata, v.exp_wd);
      end
      @(posedge CLK); #1;
      chk({nm, "_rsp_consumed"}, 32'(RSP_VALID), 32'd0);
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_req_ready"}, 32'(REQ_READY), 32'd0);
      chk({nm, "_rsp_valid"}, 32'(RSP_VALID), 32'd0);
      chk({nm, "_rsp_err"}, 32'(RSP_ERR), 32'd0);
      chk({nm, "_rsp_rdata"}, RSP_RDATA, 32'd0);
      chk({nm, "_mem_cs"}, 32'(MEM_CS), 32'd0);
      chk({nm, "_mem_r_w"}, 32'(MEM_R_W), 32'd1);
      chk({nm, "_mem_bsel"}, 32'(MEM_BSEL), 32'd0);
      chk({nm, "_mem_addr"}, MEM_ADDR, 32'd0);
      chk({nm, "_mem_wdata"}, MEM_WDATA, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int base;
      //                 we f3      addr          wdata         rdata         err lat bsel   wd
      vecs.push_back('{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 2'b11, 32'hDEADBEEF});
      vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 3, 2'b11, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE, 1'b0, 3, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b100, 32'h13,  32'h0,        32'h000000DE, 1'b0, 3, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD, 1'b0, 3, 2'b01, 32'h0});
      vecs.push_back('{1'b0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF, 1'b0, 3, 2'b01, 32'h0});
      vecs.push_back('{1'b1, 3'b000, 32'h11,  32'h12345680, 32'h0,        1'b0, 2, 2'b00, 32'h00000080});
      vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0, 3, 2'b11, 32'h0});
      vecs.push_back('{1'b1, 3'b001, 32'h11,  32'h00001234, 32'h0,        1'b1, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h3FE, 32'h0,        32'h0,        1'b1, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b000, 32'h400, 32'h0,        32'h0,        1'b1, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        1'b1, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b011, 32'h10,  32'h0,        32'h0,        1'b1, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b1, 3'b100, 32'h10,  32'h000000FF, 32'h0,        1'b1, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 1'b0, 3, 2'b11, 32'h0});
      vecs.push_back('{1'b1, 3'b010, 32'h3FC, 32'h01020304, 32'h0,        1'b0, 2, 2'b11, 32'h01020304});
      vecs.push_back('{1'b0, 3'b000, 32'h3FF, 32'h0,        32'h00000001, 1'b0, 3, 2'b00, 32'h0});
      vecs.push_back('{1'b0, 3'b001, 32'h3FE, 32'h0,        32'h00000102, 1'b0, 3, 2'b01, 32'h0});
      vecs.push_back('{1'b1, 3'b001, 32'h3FE, 32'hBEEF8001, 32'h0,        1'b0, 2, 2'b01, 32'h00008001});
      vecs.push_back('{1'b0, 3'b001, 32'h3FE, 32'h0,        32'hFFFF8001, 1'b0, 3, 2'b01, 32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h3FC, 32'h0,        32'h80010304, 1'b0, 3, 2'b11, 32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h3FD, 32'h0,        32'h0,        1'b1, 1, 2'b00, 32'h0});
      vecs.push_back('{1'b1, 3'b010, 32'h20,  32'h55667788, 32'h0,        1'b0, 2, 2'b11, 32'h55667788});

      RST = 1'b1; REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_FUNCT3 = 3'b000;
      REQ_ADDR = '0; REQ_WDATA = '0; RSP_READY = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      chk_reset_outputs("reset");
      @(negedge CLK);
      RST = 1'b0;
      #1;
      chk("after_reset_req_ready", 32'(REQ_READY), 32'd1);

      for (int unsigned i = 0; i < vecs.size(); i++)
         run_vec(vecs[i], $sformatf("v%0d", i));

      // Response stall: result held, next request waits until the response is taken
      @(negedge CLK);
      RSP_READY = 1'b0;
      REQ_WE = 1'b0; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h10; REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      REQ_FUNCT3 = 3'b000; REQ_ADDR = 32'h13;
      repeat (2) begin @(posedge CLK); #1; end
      chk("stall_valid_rise", 32'(RSP_VALID), 32'd1);
      chk("stall_rdata_rise", RSP_RDATA, 32'hDEAD80EF);
      repeat (5) begin
         @(posedge CLK); #1;
         chk("stall_valid_held", 32'(RSP_VALID), 32'd1);
         chk("stall_rdata_held", RSP_RDATA, 32'hDEAD80EF);
         chk("stall_err_held", 32'(RSP_ERR), 32'd0);
         chk("stall_req_ready", 32'(REQ_READY), 32'd0);
         chk("stall_no_cs", 32'(MEM_CS), 32'd0);
      end
      @(negedge CLK);
      RSP_READY = 1'b1;
      @(posedge CLK); #1;
      chk("stall_release_valid", 32'(RSP_VALID), 32'd0);
      chk("stall_release_ready", 32'(REQ_READY), 32'd1);
      chk("stall_release_no_cs", 32'(MEM_CS), 32'd0);
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      chk("stall_next_cs", 32'(MEM_CS), 32'd1);
      chk("stall_next_bsel", 32'(MEM_BSEL), 32'd0);
      repeat (2) begin @(posedge CLK); #1; end
      chk("stall_next_valid", 32'(RSP_VALID), 32'd1);
      chk("stall_next_rdata", RSP_RDATA, 32'hFFFFFFDE);
      @(posedge CLK); #1;

      // Reset during the ACCESS cycle of a store: nothing written, no response
      @(negedge CLK);
      REQ_WE = 1'b1; REQ_FUNCT3 = 3'b010; REQ_ADDR = 32'h20; REQ_WDATA = 32'hAAAAAAAA;
      REQ_VALID = 1'b1;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      chk("rst_mid_in_access", 32'(MEM_CS), 32'd1);
      #2;
      RST = 1'b1;
      #1;
      chk_reset_outputs("rst_mid_async");
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      base = cs_total;
      repeat (4) begin
         @(posedge CLK); #1;
         chk("rst_mid_no_rsp", 32'(RSP_VALID), 32'd0);
      end
      chk("rst_mid_no_access", 32'(cs_total - base), 32'd0);
      run_vec('{1'b0, 3'b010, 32'h20, 32'h0, 32'h55667788, 1'b0, 3, 2'b11, 32'h0}, "rst_mid_readback");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequences RISC-V load/store requests from the execute stage onto the byte-addressable data memory's single-port bus (ADDR/CS/R_W/BSEL/write-data/read-data).
- Performs alignment and range checking.
- Generates byte-select and write data.
- Captures registered read data one cycle after the access edge, then sign- or zero-extends it.
- Returns a held result to the pipeline over a valid/ready handshake.

Parameters:
MEM_BYTES, 1024, data memory size in bytes; accesses touching any byte at or above this are errors.
CHECK_ALIGN, 1, 1 = misaligned half/word accesses are errors; 0 = no alignment check, still range-checked.

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  reset, asynchronous, active-high
REQ_VALID  in  1  request present
REQ_READY  out  1  unit can accept; 1 only in IDLE with RST low
REQ_WE  in  1  1 = store, 0 = load
REQ_FUNCT3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
REQ_ADDR  in  32  byte address
REQ_WDATA  in  32  store data, low-aligned
RSP_VALID  out  1  result available, held until accepted
RSP_READY  in  1  pipeline accepts result
RSP_RDATA  out  32  extended load data; 0 for stores and errors
RSP_ERR  out  1  misaligned, out-of-range or illegal funct3
MEM_ADDR  out  32  to memory ADDR
MEM_CS  out  1  to memory CS
MEM_R_W  out  1  to memory R_W (1 read, 0 write)
MEM_BSEL  out  2  to memory BSEL (00 byte, 01 half, 11 word; 10 never driven)
MEM_WDATA  out  32  to memory write data
MEM_RDATA  in  32  from memory read data; registered by memory, unused upper bytes undefined

Behaviour:
- States: IDLE, ACCESS, RDWAIT, DONE. Reset (async) -> IDLE.
- Reset values:
  - RSP_VALID=0, RSP_ERR=0, RSP_RDATA=0.
  - MEM_CS=0, MEM_R_W=1, MEM_BSEL=00, MEM_ADDR=0, MEM_WDATA=0.
  - REQ_READY=0 while RST=1.
- Request acceptance:
  - A request is accepted on the edge where REQ_VALID and REQ_READY are both 1.
  - At that edge all request fields are registered and the error is computed.
- Error conditions:
  - Illegal funct3: loads accept only 000/001/010/100/101; stores accept only 000/001/010.
  - Misalignment (CHECK_ALIGN=1): half with ADDR[0]=1, or word with ADDR[1:0]!=00.
  - Range: ADDR+size-1 >= MEM_BYTES. Compute with 33-bit arithmetic so 0xFFFFFFFF does not wrap to pass.
- Transitions:
  - IDLE -> DONE on accept with error (RSP_ERR=1, RSP_RDATA=0). MEM_CS is never asserted, so memory is untouched.
  - IDLE -> ACCESS on accept without error.
  - ACCESS: MEM_CS=1 for exactly this cycle; MEM_ADDR, MEM_R_W=~WE and MEM_BSEL are driven from the registered request. Store -> DONE; load -> RDWAIT.
  - RDWAIT: MEM_CS=0; MEM_RDATA is captured and extended at the edge leaving RDWAIT -> DONE.
  - DONE: RSP_VALID=1 with RSP_RDATA/RSP_ERR stable. -> IDLE on the edge with RSP_READY=1; otherwise hold indefinitely.
- MEM_CS is 0 in every state except ACCESS. Memory outputs hold their last values outside ACCESS.
- Store MEM_WDATA bytes outside the access size are forced to 0.
- Load extension (only the accessed bytes of MEM_RDATA are used; undefined upper bytes must never propagate):
  - LB: sign-extend [7:0].
  - LBU: zero-extend [7:0].
  - LH: sign-extend [15:0].
  - LHU: zero-extend [15:0].
  - LW: [31:0].
- Latency from accept edge to RSP_VALID rising (RSP_READY held 1):
  - Store: 2 edges.
  - Load: 3 edges.
  - Error: 1 edge.
- Throughput: one request per (latency+1) cycles. REQ_READY=0 in ACCESS, RDWAIT and DONE.
- Reset mid-operation: state returns to IDLE immediately and MEM_CS drops asynchronously. The pending request is discarded and no response is produced. A store whose ACCESS edge has not occurred is not written.
- The block is only connected to the memory; no bypass, no outstanding-request queue.

Test Plan:
- SW 0xDEADBEEF @0x10 then LW @0x10 -> store RSP_VALID 2 edges after accept, RSP_ERR=0; load RSP_RDATA=0xDEADBEEF at 3 edges. MEM_CS high exactly 1 cycle each with MEM_BSEL=11.
- After above, LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF. MEM_BSEL=00/00/01/01.
- SB 0x12345680 @0x11, then LW @0x10 -> 0xDEAD80EF. MEM_WDATA during the SB = 0x00000080.
- SH @0x11 and LW @0x3FE (CHECK_ALIGN=1), LB @0x400, LW @0xFFFFFFFC, load funct3=011 -> each RSP_ERR=1, RSP_RDATA=0, 1-edge latency. MEM_CS never asserted; following LW @0x10 still 0xDEAD80EF.
- Response stall: LW with RSP_READY=0 for 5 cycles -> RSP_VALID and data held stable, REQ_READY=0. The next REQ_VALID is accepted only on the cycle after RSP_READY=1 is seen.
- Assert RST for 1 cycle while in ACCESS of SW 0xAAAAAAAA @0x20 (before edge) -> all outputs at reset values asynchronously, no RSP_VALID. A subsequent LW @0x20 returns the prior contents.
